controle_multiciclo: RTL

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

---
 rtl/controle_pkg.sv | 40 ++++
 rtl/decodificador_opcode.sv | 37 +++
 rtl/controle_multiciclo.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/controle_pkg.sv
// Shared definitions for the multicycle controller: state encoding,
// instruction opcodes, ALU operation codes and instruction classes.
package controle_pkg;

   // Controller states; the numeric values are visible on the estado port.
   typedef enum logic [2:0] {
      BUSCA      = 3'd0,
      DECODIFICA = 3'd1,
      EXECUTA    = 3'd2,
      MEMORIA    = 3'd3,
      ESCRITA    = 3'd4,
      ERRO       = 3'd5
   } estadoT;

   // Instruction class, decides the path taken after EXECUTA.
   typedef enum logic [1:0] {
      CLASSE_ALU = 2'd0,
      CLASSE_LW  = 2'd1,
      CLASSE_SW  = 2'd2,
      CLASSE_BEQ = 2'd3
   } classeT;

   // Opcodes found in instrucao[7:5].
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b100;
   localparam logic [2:0] OP_LW  = 3'b101;
   localparam logic [2:0] OP_SW  = 3'b110;
   localparam logic [2:0] OP_BEQ = 3'b111;

   // Operation codes sent to the ALU control decoder.
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

endpackage

// File: rtl/decodificador_opcode.sv
// Combinational opcode decoder: maps an opcode to the ALU operation,
// the ALU second-operand select and the instruction class.
module decodificador_opcode
   import controle_pkg::*;
(
   input  logic [2:0] opcode,
   output logic [2:0] opAluDec,
   output logic       aluFonte,
   output logic [1:0] classe
);

   // Arithmetic/logic opcodes pass straight through; memory ops compute
   // an address with ADD on the immediate; BEQ compares with SUB.
   always_comb begin
      opAluDec = opcode;
      aluFonte = 1'b0;
      classe   = CLASSE_ALU;
      case (opcode)
         OP_LW: begin
            opAluDec = ALU_ADD;
            aluFonte = 1'b1;
            classe   = CLASSE_LW;
         end
         OP_SW: begin
            opAluDec = ALU_ADD;
            aluFonte = 1'b1;
            classe   = CLASSE_SW;
         end
         OP_BEQ: begin
            opAluDec = ALU_SUB;
            classe   = CLASSE_BEQ;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle datapath controller: fetch/decode/execute/memory/writeback
// FSM with a memory-wait timeout that parks the controller in ERRO.
// Optional feature: define CONTROLE_CONTADOR_EN to add the instr_contadas
// output, a saturating count of completed instructions.
module controle_multiciclo
   import controle_pkg::*;
#(
   parameter int TIMEOUT_MEM = 15
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       habilita,
   input  logic [7:0] instrucao,
   input  logic       zero,
   input  logic       mem_pronto,
   output logic       mem_le,
   output logic       mem_escreve,
   output logic       ir_escreve,
   output logic       pc_escreve,
   output logic       reg_escreve,
   output logic       alu_fonte,
   output logic       mem_para_reg,
   output logic       fonte_pc,
   output logic [2:0] opAlu,
   output logic [2:0] estado,
   output logic       erro
`ifdef CONTROLE_CONTADOR_EN
   ,
   output logic [15:0] instr_contadas
`endif
);

   // Last waiting cycle allowed before the jump to ERRO.
   localparam logic [15:0] LIMITE = 16'(TIMEOUT_MEM - 1);

   estadoT      estadoAtual;
   estadoT      proxEstado;
   logic [15:0] contador;
   logic        esperando;
   logic [2:0]  opAluDec;
   logic        aluFonte;
   logic [1:0]  classe;
   logic        unusedCampos;

   // Only the opcode field matters to the controller.
   assign unusedCampos = ^instrucao[4:0];

   decodificador_opcode uDecodificador (
      .opcode   (instrucao[7:5]),
      .opAluDec (opAluDec),
      .aluFonte (aluFonte),
      .classe   (classe)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) estadoAtual <= BUSCA;
      else        estadoAtual <= proxEstado;
   end

   // Next state and outputs; everything stays quiet while reset is held.
   always_comb begin
      proxEstado   = estadoAtual;
      esperando    = 1'b0;
      mem_le       = 1'b0;
      mem_escreve  = 1'b0;
      ir_escreve   = 1'b0;
      pc_escreve   = 1'b0;
      reg_escreve  = 1'b0;
      alu_fonte    = 1'b0;
      mem_para_reg = 1'b0;
      fonte_pc     = 1'b0;
      opAlu        = ALU_AND;
      if (rst_n) begin
         case (estadoAtual)
            BUSCA: begin
               if (habilita) begin
                  mem_le = 1'b1;
                  if (mem_pronto) begin
                     ir_escreve = 1'b1;
                     pc_escreve = 1'b1;
                     proxEstado = DECODIFICA;
                  end else begin
                     esperando = 1'b1;
                  end
               end
            end
            DECODIFICA: proxEstado = EXECUTA;
            EXECUTA: begin
               opAlu     = opAluDec;
               alu_fonte = aluFonte;
               case (classe)
                  CLASSE_LW, CLASSE_SW: proxEstado = MEMORIA;
                  CLASSE_BEQ: begin
                     pc_escreve = zero;
                     fonte_pc   = zero;
                     proxEstado = BUSCA;
                  end
                  default: proxEstado = ESCRITA;
               endcase
            end
            MEMORIA: begin
               mem_le      = (classe == CLASSE_LW);
               mem_escreve = (classe == CLASSE_SW);
               if (mem_pronto) begin
                  proxEstado = (classe == CLASSE_LW) ? ESCRITA : BUSCA;
               end else begin
                  esperando = 1'b1;
               end
            end
            ESCRITA: begin
               reg_escreve  = 1'b1;
               mem_para_reg = (classe == CLASSE_LW);
               proxEstado   = BUSCA;
            end
            ERRO:    proxEstado = ERRO;
            default: proxEstado = BUSCA;
         endcase
         if (esperando && (contador >= LIMITE)) proxEstado = ERRO;
      end
   end

   // Wait counter: counts consecutive memory-wait cycles in one state,
   // cleared whenever the wait ends or the state changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         contador <= '0;
      else if (esperando && (proxEstado == estadoAtual))
         contador <= contador + 16'd1;
      else
         contador <= '0;
   end

   // Debug/status outputs derived from the state.
   always_comb begin
      estado = estadoAtual;
      erro   = (estadoAtual == ERRO);
   end

`ifdef CONTROLE_CONTADOR_EN
   // Completed-instruction counter: bumps on each return to BUSCA.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         instr_contadas <= '0;
      else if ((estadoAtual == EXECUTA || estadoAtual == MEMORIA ||
                estadoAtual == ESCRITA) && (proxEstado == BUSCA) &&
               (instr_contadas != 16'hFFFF))
         instr_contadas <= instr_contadas + 16'd1;
   end
`endif

endmodule
